// File: rtl/data_addr_gen.sv
// Registered data-memory address generator: selects B/A/K/zero/B+K or a stack
// address, holding one outstanding address toward Data Memory under valid/ready.
module data_addr_gen #(
  parameter int                DATA_W  = 8,
  parameter int                ADDR_W  = 8,
  parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        sel,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic [DATA_W-1:0] k_in,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] sp,
  output logic              stack_ovf,
  output logic              stack_unf,
  output logic              sel_err
);

  typedef enum logic [2:0] {
    SEL_B    = 3'b000,
    SEL_A    = 3'b001,
    SEL_K    = 3'b010,
    SEL_ZERO = 3'b011,
    SEL_PUSH = 3'b100,
    SEL_POP  = 3'b101,
    SEL_BK   = 3'b110,
    SEL_RSVD = 3'b111
  } sel_e;

  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic              stack_ovf_q, stack_ovf_d;
  logic              stack_unf_q, stack_unf_d;
  logic              sel_err_q, sel_err_d;

  logic [ADDR_W-1:0] a_fit, b_fit, k_fit;
  logic [ADDR_W-1:0] new_addr;
  logic              accept;
  logic              issue;
  sel_e              mode;

  // Operands are fitted to the address width: truncate when wider, zero-extend when narrower.
  if (DATA_W >= ADDR_W) begin : g_trunc
    assign a_fit = a_in[ADDR_W-1:0];
    assign b_fit = b_in[ADDR_W-1:0];
    assign k_fit = k_in[ADDR_W-1:0];
  end else begin : g_zext
    assign a_fit = {{(ADDR_W-DATA_W){1'b0}}, a_in};
    assign b_fit = {{(ADDR_W-DATA_W){1'b0}}, b_in};
    assign k_fit = {{(ADDR_W-DATA_W){1'b0}}, k_in};
  end

  assign mode      = sel_e'(sel);
  assign req_ready = !mem_valid_q || mem_ready;
  assign accept    = req_valid && req_ready;

  always_comb begin
    issue       = 1'b0;
    new_addr    = mem_addr_q;
    sp_d        = sp_q;
    stack_ovf_d = 1'b0;
    stack_unf_d = 1'b0;
    sel_err_d   = 1'b0;
    if (accept) begin
      case (mode)
        SEL_B:    begin issue = 1'b1; new_addr = b_fit; end
        SEL_A:    begin issue = 1'b1; new_addr = a_fit; end
        SEL_K:    begin issue = 1'b1; new_addr = k_fit; end
        SEL_ZERO: begin issue = 1'b1; new_addr = '0; end
        SEL_BK:   begin issue = 1'b1; new_addr = b_fit + k_fit; end
        // Descending stack: push pre-decrements, pop post-increments.
        SEL_PUSH: begin
          if (sp_q == '0) begin
            stack_ovf_d = 1'b1;
          end else begin
            issue    = 1'b1;
            new_addr = sp_q - ADDR_W'(1);
            sp_d     = sp_q - ADDR_W'(1);
          end
        end
        SEL_POP: begin
          if (sp_q == SP_INIT) begin
            stack_unf_d = 1'b1;
          end else begin
            issue    = 1'b1;
            new_addr = sp_q;
            sp_d     = sp_q + ADDR_W'(1);
          end
        end
        default: sel_err_d = 1'b1;
      endcase
    end
  end

  // A new address replaces the held one; otherwise a consumed address drains.
  always_comb begin
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    if (issue) begin
      mem_valid_d = 1'b1;
      mem_addr_d  = new_addr;
    end else if (mem_ready) begin
      mem_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      sp_q        <= SP_INIT;
      stack_ovf_q <= 1'b0;
      stack_unf_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      sp_q        <= sp_d;
      stack_ovf_q <= stack_ovf_d;
      stack_unf_q <= stack_unf_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign sp        = sp_q;
  assign stack_ovf = stack_ovf_q;
  assign stack_unf = stack_unf_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_data_addr_gen.sv
// Self-checking bench for data_addr_gen: directed scenarios plus randomized traffic
// compared against a request-level model of the address generator.
module tb_data_addr_gen;

  localparam int SP_EMPTY = 255;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] sel;
  logic [7:0] a_in, b_in, k_in;
  logic       mem_valid;
  logic       mem_ready;
  logic [7:0] mem_addr;
  logic [7:0] sp;
  logic       stack_ovf, stack_unf, sel_err;

  int checks = 0;
  int errors = 0;

  // Model state: outstanding address, stack pointer and last-cycle flag pulses.
  bit m_valid, m_ovf, m_unf, m_err;
  int m_addr, m_sp;

  data_addr_gen #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .sel(sel), .a_in(a_in), .b_in(b_in), .k_in(k_in),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .sp(sp),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf), .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout reached before summary");
    $fatal(1, "[TB] timeout");
  end

  // Advance one clock; the model computes the outcome of the request presented now.
  task automatic tick();
    bit acc, iss, nv, novf, nunf, nerr;
    int na, nsp;
    acc  = req_valid && (!m_valid || mem_ready);
    iss  = 0; novf = 0; nunf = 0; nerr = 0;
    na   = m_addr;
    nsp  = m_sp;
    if (acc) begin
      case (sel)
        3'd0: begin iss = 1; na = b_in; end
        3'd1: begin iss = 1; na = a_in; end
        3'd2: begin iss = 1; na = k_in; end
        3'd3: begin iss = 1; na = 0; end
        3'd4: if (m_sp == 0) novf = 1; else begin nsp = m_sp - 1; na = nsp; iss = 1; end
        3'd5: if (m_sp == SP_EMPTY) nunf = 1; else begin na = m_sp; nsp = m_sp + 1; iss = 1; end
        3'd6: begin iss = 1; na = (int'(b_in) + int'(k_in)) % 256; end
        default: nerr = 1;
      endcase
    end
    nv = iss ? 1'b1 : (mem_ready ? 1'b0 : m_valid);
    if (!rst_n) begin
      nv = 0; na = 0; nsp = SP_EMPTY; novf = 0; nunf = 0; nerr = 0;
    end
    @(posedge clk);
    #1;
    m_valid = nv; m_addr = na; m_sp = nsp; m_ovf = novf; m_unf = nunf; m_err = nerr;
  endtask

  task automatic drive(input bit v, input logic [2:0] s, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] k, input bit rdy);
    req_valid = v; sel = s; a_in = a; b_in = b; k_in = k; mem_ready = rdy;
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive(0, 3'd0, 8'h00, 8'h00, 8'h00, 1);
    tick();
    tick();
    rst_n = 1;
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", mem_valid); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("[TB] FAIL reset_addr got %h want 00", mem_addr); end
    checks++; if (sp !== 8'hFF) begin errors++; $display("[TB] FAIL reset_sp got %h want ff", sp); end
    checks++; if ({stack_ovf, stack_unf, sel_err} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b want 000", {stack_ovf, stack_unf, sel_err}); end
  endtask

  task automatic test_select_modes();
    drive(1, 3'd0, 8'h00, 8'h3C, 8'h00, 1); tick();
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 8'h3C) begin errors++; $display("[TB] FAIL sel_b got v=%b a=%h want v=1 a=3c", mem_valid, mem_addr); end
    checks++; if (sp !== 8'hFF || {stack_ovf, stack_unf, sel_err} !== 3'b000) begin errors++; $display("[TB] FAIL sel_b_side got sp=%h f=%b want ff 000", sp, {stack_ovf, stack_unf, sel_err}); end
    drive(1, 3'd6, 8'h00, 8'hF0, 8'h20, 1); tick();
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 8'h10) begin errors++; $display("[TB] FAIL sel_bk_wrap got v=%b a=%h want v=1 a=10", mem_valid, mem_addr); end
    drive(1, 3'd3, 8'h77, 8'h66, 8'h55, 1); tick();
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 8'h00) begin errors++; $display("[TB] FAIL sel_zero got v=%b a=%h want v=1 a=00", mem_valid, mem_addr); end
    drive(1, 3'd1, 8'h5A, 8'h66, 8'h55, 1); tick();
    checks++; if (mem_addr !== 8'h5A) begin errors++; $display("[TB] FAIL sel_a got %h want 5a", mem_addr); end
    drive(1, 3'd2, 8'h5A, 8'h66, 8'hA7, 1); tick();
    checks++; if (mem_addr !== 8'hA7) begin errors++; $display("[TB] FAIL sel_k got %h want a7", mem_addr); end
  endtask

  task automatic test_stack();
    drive(0, 3'd0, 8'h00, 8'h00, 8'h00, 1); tick();
    drive(1, 3'd5, 8'h00, 8'h00, 8'h00, 1); tick();
    checks++; if (stack_unf !== 1'b1 || mem_valid !== 1'b0 || sp !== 8'hFF) begin errors++; $display("[TB] FAIL pop_empty got unf=%b v=%b sp=%h want 1 0 ff", stack_unf, mem_valid, sp); end
    drive(0, 3'd5, 8'h00, 8'h00, 8'h00, 1); tick();
    checks++; if (stack_unf !== 1'b0) begin errors++; $display("[TB] FAIL unf_pulse got %b want 0", stack_unf); end
    drive(1, 3'd4, 8'h00, 8'h00, 8'h00, 1); tick();
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 8'hFE) begin errors++; $display("[TB] FAIL push1 got v=%b a=%h want 1 fe", mem_valid, mem_addr); end
    tick();
    checks++; if (mem_addr !== 8'hFD || sp !== 8'hFD) begin errors++; $display("[TB] FAIL push2 got a=%h sp=%h want fd fd", mem_addr, sp); end
    drive(1, 3'd5, 8'h00, 8'h00, 8'h00, 1); tick();
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 8'hFD || sp !== 8'hFE) begin errors++; $display("[TB] FAIL pop got v=%b a=%h sp=%h want 1 fd fe", mem_valid, mem_addr, sp); end
  endtask

  task automatic test_overflow();
    int n = 0;
    drive(1, 3'd4, 8'h00, 8'h00, 8'h00, 1);
    while (m_sp != 0 && n < 300) begin tick(); n++; end
    checks++; if (sp !== 8'h00 || mem_addr !== 8'h00) begin errors++; $display("[TB] FAIL fill_stack got sp=%h a=%h want 00 00", sp, mem_addr); end
    tick();
    checks++; if (stack_ovf !== 1'b1 || sp !== 8'h00 || mem_valid !== 1'b0) begin errors++; $display("[TB] FAIL push_full got ovf=%b sp=%h v=%b want 1 00 0", stack_ovf, sp, mem_valid); end
    drive(0, 3'd4, 8'h00, 8'h00, 8'h00, 1); tick();
    checks++; if (stack_ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_pulse got %b want 0", stack_ovf); end
  endtask

  task automatic test_backpressure();
    drive(1, 3'd2, 8'h00, 8'h00, 8'h55, 0); tick();
    drive(1, 3'd1, 8'h11, 8'h00, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_ready[%0d] got %b want 0", i, req_ready); end
      tick();
      checks++; if (mem_valid !== 1'b1 || mem_addr !== 8'h55) begin errors++; $display("[TB] FAIL hold_addr[%0d] got v=%b a=%h want 1 55", i, mem_valid, mem_addr); end
    end
    mem_ready = 1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL handoff_ready got %b want 1", req_ready); end
    tick();
    checks++; if (mem_valid !== 1'b1 || mem_addr !== 8'h11) begin errors++; $display("[TB] FAIL handoff got v=%b a=%h want 1 11", mem_valid, mem_addr); end
    drive(0, 3'd0, 8'h00, 8'h00, 8'h00, 1); tick();
    checks++; if (mem_valid !== 1'b0 || mem_addr !== 8'h11) begin errors++; $display("[TB] FAIL drain got v=%b a=%h want 0 11", mem_valid, mem_addr); end
  endtask

  task automatic test_reset_midflight();
    rst_n = 0; tick(); rst_n = 1;
    drive(1, 3'd4, 8'h00, 8'h00, 8'h00, 1); tick(); tick();
    checks++; if (mem_valid !== 1'b1 || sp !== 8'hFD) begin errors++; $display("[TB] FAIL pre_reset got v=%b sp=%h want 1 fd", mem_valid, sp); end
    rst_n = 0;
    drive(0, 3'd0, 8'h00, 8'h00, 8'h00, 0); tick();
    rst_n = 1;
    checks++; if (mem_valid !== 1'b0 || mem_addr !== 8'h00 || sp !== 8'hFF) begin errors++; $display("[TB] FAIL midflight_reset got v=%b a=%h sp=%h want 0 00 ff", mem_valid, mem_addr, sp); end
  endtask

  task automatic test_reserved();
    drive(1, 3'd7, 8'h12, 8'h34, 8'h56, 1); tick();
    checks++; if (sel_err !== 1'b1 || mem_valid !== 1'b0 || mem_addr !== 8'h00 || sp !== 8'hFF) begin errors++; $display("[TB] FAIL reserved got err=%b v=%b a=%h sp=%h want 1 0 00 ff", sel_err, mem_valid, mem_addr, sp); end
    drive(0, 3'd7, 8'h12, 8'h34, 8'h56, 1); tick();
    checks++; if (sel_err !== 1'b0) begin errors++; $display("[TB] FAIL err_pulse got %b want 0", sel_err); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
            8'($urandom), 8'($urandom), $urandom_range(0, 2) != 0);
      if ($urandom_range(0, 2) == 0) sel = 3'd4;
      #1;
      checks++; if (req_ready !== (!m_valid || mem_ready)) begin errors++; $display("[TB] FAIL rnd_ready[%0d] got %b want %b", i, req_ready, (!m_valid || mem_ready)); end
      tick();
      checks++; if (mem_valid !== m_valid || mem_addr !== 8'(m_addr) || sp !== 8'(m_sp)) begin errors++; $display("[TB] FAIL rnd_state[%0d] got v=%b a=%h sp=%h want v=%b a=%h sp=%h", i, mem_valid, mem_addr, sp, m_valid, 8'(m_addr), 8'(m_sp)); end
      checks++; if ({stack_ovf, stack_unf, sel_err} !== {m_ovf, m_unf, m_err}) begin errors++; $display("[TB] FAIL rnd_flags[%0d] got %b want %b", i, {stack_ovf, stack_unf, sel_err}, {m_ovf, m_unf, m_err}); end
    end
  endtask

  initial begin
    m_valid = 0; m_addr = 0; m_sp = SP_EMPTY; m_ovf = 0; m_unf = 0; m_err = 0;
    test_reset();
    test_select_modes();
    test_stack();
    test_overflow();
    test_backpressure();
    test_reset_midflight();
    test_reserved();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
